// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding.
// Captures decoded operands/control from decode, resolves RAW hazards against
// EX/MEM and MEM/WB writers, and drives the ALU operand buses, the ALU control
// code, the forwarded store data and the pass-through control to EX/MEM.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_wr,
    input  logic [3:0]    id_aluctrl,
    input  logic          id_alusrc,
    input  logic          id_azero,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          hold,
    input  logic          bubble,
    input  logic          flush,
    input  logic [RW-1:0] exm_wr,
    input  logic          exm_regwrite,
    input  logic [DW-1:0] exm_result,
    input  logic [RW-1:0] wb_wr,
    input  logic          wb_regwrite,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] alu_op_a,
    output logic [DW-1:0] alu_op_b,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wr,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic [1:0]    ex_fwd_a,
    output logic [1:0]    ex_fwd_b
);

    // addu encodes as all-zero, so a cleared stage is a harmless NOP
    localparam logic [3:0] ALUOP_ADDU = 4'b0000;
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_WB     = 2'b01;
    localparam logic [1:0] FWD_EXM    = 2'b10;

    logic [DW-1:0] rs_data_r;
    logic [DW-1:0] rt_data_r;
    logic [DW-1:0] imm_r;
    logic [RW-1:0] rs_r;
    logic [RW-1:0] rt_r;
    logic [RW-1:0] wr_r;
    logic [3:0]    aluctrl_r;
    logic          alusrc_r;
    logic          azero_r;
    logic          regwrite_r;
    logic          memread_r;
    logic          memwrite_r;
    logic          memtoreg_r;

    logic [1:0]    fwd_a_sel_s;
    logic [1:0]    fwd_b_sel_s;
    logic [DW-1:0] fwd_a_data_s;
    logic [DW-1:0] fwd_b_data_s;

    // Pick the youngest in-flight writer of src; register 0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [RW-1:0] src,
        input logic [RW-1:0] e_wr,
        input logic          e_we,
        input logic [RW-1:0] w_wr,
        input logic          w_we
    );
        logic [1:0] sel;
        if (e_we && (e_wr != {RW{1'b0}}) && (e_wr == src)) begin
            sel = FWD_EXM;
        end else if (w_we && (w_wr != {RW{1'b0}}) && (w_wr == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    // Stage register: flush beats hold, hold beats bubble, bubble beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_data_r  <= {DW{1'b0}};
            rt_data_r  <= {DW{1'b0}};
            imm_r      <= {DW{1'b0}};
            rs_r       <= {RW{1'b0}};
            rt_r       <= {RW{1'b0}};
            wr_r       <= {RW{1'b0}};
            aluctrl_r  <= ALUOP_ADDU;
            alusrc_r   <= 1'b0;
            azero_r    <= 1'b0;
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
        end else if (flush || (bubble && !hold)) begin
            rs_data_r  <= {DW{1'b0}};
            rt_data_r  <= {DW{1'b0}};
            imm_r      <= {DW{1'b0}};
            rs_r       <= {RW{1'b0}};
            rt_r       <= {RW{1'b0}};
            wr_r       <= {RW{1'b0}};
            aluctrl_r  <= ALUOP_ADDU;
            alusrc_r   <= 1'b0;
            azero_r    <= 1'b0;
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
        end else if (hold) begin
            rs_data_r  <= rs_data_r;
            rt_data_r  <= rt_data_r;
            imm_r      <= imm_r;
            rs_r       <= rs_r;
            rt_r       <= rt_r;
            wr_r       <= wr_r;
            aluctrl_r  <= aluctrl_r;
            alusrc_r   <= alusrc_r;
            azero_r    <= azero_r;
            regwrite_r <= regwrite_r;
            memread_r  <= memread_r;
            memwrite_r <= memwrite_r;
            memtoreg_r <= memtoreg_r;
        end else begin
            rs_data_r  <= id_rs_data;
            rt_data_r  <= id_rt_data;
            imm_r      <= id_imm;
            rs_r       <= id_rs;
            rt_r       <= id_rt;
            wr_r       <= id_wr;
            aluctrl_r  <= id_aluctrl;
            alusrc_r   <= id_alusrc;
            azero_r    <= id_azero;
            regwrite_r <= id_regwrite;
            memread_r  <= id_memread;
            memwrite_r <= id_memwrite;
            memtoreg_r <= id_memtoreg;
        end
    end

    // Forwarding muxes track the live EX/MEM and MEM/WB buses, also while held.
    always_comb begin
        fwd_a_sel_s = fwd_select(rs_r, exm_wr, exm_regwrite, wb_wr, wb_regwrite);
        fwd_b_sel_s = fwd_select(rt_r, exm_wr, exm_regwrite, wb_wr, wb_regwrite);
        case (fwd_a_sel_s)
            FWD_EXM: fwd_a_data_s = exm_result;
            FWD_WB:  fwd_a_data_s = wb_data;
            default: fwd_a_data_s = rs_data_r;
        endcase
        case (fwd_b_sel_s)
            FWD_EXM: fwd_b_data_s = exm_result;
            FWD_WB:  fwd_b_data_s = wb_data;
            default: fwd_b_data_s = rt_data_r;
        endcase
    end

    // Operand overrides (lui zero, immediate); the debug selects report 00 when overridden.
    always_comb begin
        if (azero_r) begin
            alu_op_a = {DW{1'b0}};
            ex_fwd_a = FWD_REG;
        end else begin
            alu_op_a = fwd_a_data_s;
            ex_fwd_a = fwd_a_sel_s;
        end
        if (alusrc_r) begin
            alu_op_b = imm_r;
            ex_fwd_b = FWD_REG;
        end else begin
            alu_op_b = fwd_b_data_s;
            ex_fwd_b = fwd_b_sel_s;
        end
        // store data is taken ahead of the immediate mux so sw stores the newest rt
        ex_store_data = fwd_b_data_s;
    end

    assign alu_ctrl    = aluctrl_r;
    assign ex_wr       = wr_r;
    assign ex_regwrite = regwrite_r;
    assign ex_memread  = memread_r;
    assign ex_memwrite = memwrite_r;
    assign ex_memtoreg = memtoreg_r;

endmodule
